// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one decoded MIPS instruction to a combinational ALU
// and returns its result, zero flag, branch decision and error over valid/ready.
module alu_issue_ctrl #(
  parameter int          W        = 32,
  parameter logic [3:0]  IDLE_CTR = 4'b1111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_instr,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic [W-1:0] alu_di1,
  output logic [W-1:0] alu_di2,
  output logic [3:0]   alu_ctr,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_taken,
  output logic         rsp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t       r_state, w_next;
  logic [W-1:0] r_di1, r_di2, r_result;
  logic [3:0]   r_ctr;
  logic         r_zero, r_taken, r_err, r_beq, r_bne;

  logic [5:0]   w_op, w_funct;
  logic [15:0]  w_imm;
  logic [3:0]   w_ctr;
  logic [W-1:0] w_di2;
  logic         w_err, w_beq, w_bne;

  assign w_op    = req_instr[31:26];
  assign w_funct = req_instr[5:0];
  assign w_imm   = req_instr[15:0];

  always_comb begin
    w_ctr = IDLE_CTR;
    w_di2 = req_b;
    w_err = 1'b0;
    w_beq = 1'b0;
    w_bne = 1'b0;
    case (w_op)
      6'b000000: begin
        case (w_funct)
          6'b100100:            w_ctr = 4'b0000;
          6'b100101:            w_ctr = 4'b0001;
          6'b100000, 6'b100001: w_ctr = 4'b0010;
          6'b100010, 6'b100011: w_ctr = 4'b0110;
          6'b101010:            w_ctr = 4'b0111;
          6'b100111:            w_ctr = 4'b1100;
          default:              w_err = 1'b1;
        endcase
      end
      6'b001000: begin w_ctr = 4'b0010; w_di2 = {{(W-16){w_imm[15]}}, w_imm}; end
      6'b001010: begin w_ctr = 4'b0111; w_di2 = {{(W-16){w_imm[15]}}, w_imm}; end
      6'b001100: begin w_ctr = 4'b0000; w_di2 = {{(W-16){1'b0}}, w_imm}; end
      6'b001101: begin w_ctr = 4'b0001; w_di2 = {{(W-16){1'b0}}, w_imm}; end
      6'b000100: begin w_ctr = 4'b0110; w_beq = 1'b1; end
      6'b000101: begin w_ctr = 4'b0110; w_bne = 1'b1; end
      default:   w_err = 1'b1;
    endcase
    if (w_err) w_ctr = IDLE_CTR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_err ? RESP : EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_di1    <= '0;
      r_di2    <= '0;
      r_ctr    <= IDLE_CTR;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_taken  <= 1'b0;
      r_err    <= 1'b0;
      r_beq    <= 1'b0;
      r_bne    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          // An illegal op keeps the ALU on its default code so it never sees live operands.
          r_di1    <= w_err ? '0 : req_a;
          r_di2    <= w_err ? '0 : w_di2;
          r_ctr    <= w_ctr;
          r_result <= '0;
          r_zero   <= 1'b0;
          r_taken  <= 1'b0;
          r_err    <= w_err;
          r_beq    <= w_beq;
          r_bne    <= w_bne;
        end
        EXEC: begin
          r_result <= alu_out;
          r_zero   <= alu_zero;
          r_taken  <= (r_beq & alu_zero) | (r_bne & ~alu_zero);
        end
        RESP: if (rsp_ready) r_ctr <= IDLE_CTR;
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == RESP);
  assign alu_di1    = r_di1;
  assign alu_di2    = r_di2;
  assign alu_ctr    = r_ctr;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_taken  = r_taken;
  assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized check of alu_issue_ctrl against an instruction-level model
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_ready, rsp_valid;
  logic [31:0] req_instr, req_a, req_b;
  logic [31:0] alu_di1, alu_di2, alu_out, rsp_result;
  logic [3:0]  alu_ctr;
  logic        alu_zero, rsp_zero, rsp_taken, rsp_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.W(32), .IDLE_CTR(4'b1111)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_a(req_a), .req_b(req_b),
    .alu_di1(alu_di1), .alu_di2(alu_di2), .alu_ctr(alu_ctr),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_taken(rsp_taken), .rsp_err(rsp_err)
  );

  // Combinational ALU the block drives
  always_comb begin
    case (alu_ctr)
      4'b0000: alu_out = alu_di1 & alu_di2;
      4'b0001: alu_out = alu_di1 | alu_di2;
      4'b0010: alu_out = alu_di1 + alu_di2;
      4'b0110: alu_out = alu_di1 - alu_di2;
      4'b0111: alu_out = ($signed(alu_di1) < $signed(alu_di2)) ? 32'd1 : 32'd0;
      4'b1100: alu_out = ~(alu_di1 | alu_di2);
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  typedef struct packed {
    logic        err;
    logic [3:0]  ctr;
    logic [31:0] di2;
    logic [31:0] res;
    logic        zero;
    logic        taken;
  } exp_t;

  // Instruction semantics computed directly from the operands
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] se, ze;
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    e = '0;
    e.di2 = b;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h24:        begin e.ctr = 4'h0; e.res = a & b; end
        6'h25:        begin e.ctr = 4'h1; e.res = a | b; end
        6'h20, 6'h21: begin e.ctr = 4'h2; e.res = a + b; end
        6'h22, 6'h23: begin e.ctr = 4'h6; e.res = a - b; end
        6'h2a:        begin e.ctr = 4'h7; e.res = {31'd0, $signed(a) < $signed(b)}; end
        6'h27:        begin e.ctr = 4'hC; e.res = ~(a | b); end
        default:      e.err = 1'b1;
      endcase
      6'h08:   begin e.ctr = 4'h2; e.di2 = se; e.res = a + se; end
      6'h0a:   begin e.ctr = 4'h7; e.di2 = se; e.res = {31'd0, $signed(a) < $signed(se)}; end
      6'h0c:   begin e.ctr = 4'h0; e.di2 = ze; e.res = a & ze; end
      6'h0d:   begin e.ctr = 4'h1; e.di2 = ze; e.res = a | ze; end
      6'h04:   begin e.ctr = 4'h6; e.res = a - b; e.taken = (a == b); end
      6'h05:   begin e.ctr = 4'h6; e.res = a - b; e.taken = (a != b); end
      default: e.err = 1'b1;
    endcase
    if (e.err) begin
      e.ctr = 4'hF; e.res = '0; e.di2 = '0; e.taken = 1'b0; e.zero = 1'b0;
    end else begin
      e.zero = (e.res == 32'd0);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_rsp(input exp_t e);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_result", rsp_result, e.res);
    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
    chk("rsp_taken", 32'(rsp_taken), 32'(e.taken));
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    chk("ctr_hold", 32'(alu_ctr), 32'(e.ctr));
  endtask

  task automatic txn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int   lat;
    e = ref_model(ins, a, b);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_instr = ins; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_instr = $urandom; req_a = $urandom; req_b = $urandom;
    chk("alu_ctr", 32'(alu_ctr), 32'(e.ctr));
    if (!e.err) begin
      chk("alu_di1", alu_di1, a);
      chk("alu_di2", alu_di2, e.di2);
    end
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), e.err ? 32'd1 : 32'd2);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      chk_rsp(e);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk_rsp(e);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("ctr_idle", 32'(alu_ctr), 32'hF);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_alu_ctr"}, 32'(alu_ctr), 32'hF);
    chk({tag, "_di1"}, alu_di1, 32'd0);
    chk({tag, "_di2"}, alu_di2, 32'd0);
    chk({tag, "_result"}, rsp_result, 32'd0);
    chk({tag, "_flags"}, {29'd0, rsp_zero, rsp_taken, rsp_err}, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn_tab [8] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2a, 6'h27};
    logic [5:0] op_tab [6] = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h04, 6'h05};
    int         k;
    logic [31:0] r;
    k = $urandom_range(0, 15);
    r = $urandom;
    if (k < 8)       return {6'h00, r[19:0], fn_tab[k]};
    else if (k < 14) return {op_tab[k-8], r[25:0]};
    else if (k == 14) return r;
    else             return {6'h00, r[25:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins, a, b;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_instr = '0; req_a = '0; req_b = '0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk); rst = 1'b0;

    txn({6'h00, 20'h0, 6'h20}, 32'd5, 32'd7, 0);
    txn({6'h00, 20'h0, 6'h22}, 32'h1234, 32'h1234, 1);
    txn({6'h04, 10'h0, 16'h0010}, 32'd9, 32'd9, 0);
    txn({6'h05, 10'h0, 16'h0010}, 32'd9, 32'd9, 0);
    txn({6'h08, 10'h0, 16'hFFFF}, 32'd1, 32'd0, 0);
    txn({6'h0d, 10'h0, 16'hFFFF}, 32'h12340000, 32'd0, 0);
    txn({6'h23, 10'h0, 16'h0004}, 32'd3, 32'd4, 0);
    txn({6'h00, 20'h0, 6'h2a}, 32'hFFFFFFFF, 32'd1, 5);

    // Reset mid-flight discards the op
    @(negedge clk);
    req_valid = 1'b1; req_instr = {6'h00, 20'h0, 6'h20}; req_a = 32'd1; req_b = 32'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk); rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;
    txn({6'h0c, 10'h0, 16'h00F0}, 32'hFFFF_FF3C, 32'd0, 0);

    for (int n = 0; n < 60; n++) begin
      ins = rand_instr();
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      txn(ins, a, b, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
